// File: rtl/pipe_adder_pkg.sv
// rtl/pipe_adder_pkg.sv - shared types and parameter check for pipe_adder
//
// Purpose: per-stage control record and the WIDTH/STAGES legality check used
// at elaboration time by pipe_adder.
// Ports: none (package).

package pipe_adder_pkg;

    // Control state carried by every pipeline stage.
    typedef struct packed {
        logic valid;
        logic carry;
    } stage_ctrl_t;

    // WIDTH must split into STAGES equal, non-empty slices.
    function automatic bit params_ok(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/pipe_adder_slice.sv
// rtl/pipe_adder_slice.sv - combinational W-bit ripple-carry adder slice
//
// Purpose: one bit-slice of the pipelined adder, built as a chain of full adders.
// Ports:
//   a, b  in  W  slice operands
//   ci    in  1  carry into bit 0
//   s     out W  slice sum
//   co    out 1  carry out of bit W-1

module adder_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);

    logic c;

    always_comb begin
        s = '0;
        c = ci;
        for (int i = 0; i < W; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        co = c;
    end

endmodule

// File: rtl/pipe_adder.sv
// rtl/pipe_adder.sv - pipelined ripple-carry adder with valid/ready handshake
//
// Purpose: WIDTH-bit a + b + ci split into STAGES slices of CHUNK bits, one
// slice resolved per stage with the carry registered between stages.
// Optional macro PIPE_ADDER_SUB_EN adds a 'sub' input selecting a - b.
// Ports:
//   clk        in  1      rising-edge clock
//   rst        in  1      synchronous active-high reset
//   in_valid   in  1      a, b, ci (and sub) valid
//   in_ready   out 1      input accepted this cycle
//   a, b       in  WIDTH  unsigned operands
//   ci         in  1      carry-in (ignored when sub=1)
//   sub        in  1      only with PIPE_ADDER_SUB_EN: compute a + ~b + 1
//   out_valid  out 1      sum/co valid
//   out_ready  in  1      downstream accepts output
//   sum        out WIDTH  result modulo 2^WIDTH
//   co         out 1      carry out of bit WIDTH-1 (no-borrow when subtracting)

module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
`ifdef PIPE_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co
);

    localparam int CHUNK = WIDTH / STAGES;

    if (!params_ok(WIDTH, STAGES)) begin : g_bad_params
        $error("pipe_adder: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
    end

    // Operand B and carry-in as seen by stage 0. Subtraction inverts B once
    // here; downstream stages only ever see the already-inverted bits.
    logic [WIDTH-1:0] b_eff;
    logic             ci_eff;

`ifdef PIPE_ADDER_SUB_EN
    assign b_eff  = sub ? ~b : b;
    assign ci_eff = sub ? 1'b1 : ci;
`else
    assign b_eff  = b;
    assign ci_eff = ci;
`endif

    // Per-stage state exported from each generate block.
    logic             valid_w     [STAGES];
    logic             carry_w     [STAGES];
    logic [WIDTH-1:0] sum_w       [STAGES];
    logic [WIDTH-1:0] opa_w       [STAGES];
    logic [WIDTH-1:0] opb_w       [STAGES];
    logic             stage_ready [STAGES+1];

    assign stage_ready[STAGES] = out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        stage_ctrl_t      ctrl_q;
        logic [WIDTH-1:0] sum_q;
        logic [WIDTH-1:0] opa_q;
        logic [WIDTH-1:0] opb_q;

        logic             up_valid;
        logic [CHUNK-1:0] slice_a;
        logic [CHUNK-1:0] slice_b;
        logic             slice_ci;
        logic [CHUNK-1:0] slice_s;
        logic             slice_co;
        logic [WIDTH-1:0] up_sum;
        logic [WIDTH-1:0] up_opa;
        logic [WIDTH-1:0] up_opb;

        if (k == 0) begin : g_head
            assign up_valid = in_valid;
            assign up_opa   = a;
            assign up_opb   = b_eff;
            assign up_sum   = '0;
            assign slice_ci = ci_eff;
        end else begin : g_body
            assign up_valid = valid_w[k-1];
            assign up_opa   = opa_w[k-1];
            assign up_opb   = opb_w[k-1];
            assign up_sum   = sum_w[k-1];
            assign slice_ci = carry_w[k-1];
        end

        assign slice_a = up_opa[k*CHUNK +: CHUNK];
        assign slice_b = up_opb[k*CHUNK +: CHUNK];

        adder_slice #(.W(CHUNK)) u_slice (
            .a  (slice_a),
            .b  (slice_b),
            .ci (slice_ci),
            .s  (slice_s),
            .co (slice_co)
        );

        // A stage can take new data when empty or when its contents move on.
        assign stage_ready[k] = !ctrl_q.valid || stage_ready[k+1];

        always_ff @(posedge clk) begin
            if (rst) begin
                ctrl_q <= '0;
                sum_q  <= '0;
                opa_q  <= '0;
                opb_q  <= '0;
            end else if (stage_ready[k]) begin
                ctrl_q.valid <= up_valid;
                if (up_valid) begin
                    ctrl_q.carry                 <= slice_co;
                    sum_q                        <= up_sum;
                    sum_q[k*CHUNK +: CHUNK]      <= slice_s;
                    opa_q                        <= up_opa;
                    opb_q                        <= up_opb;
                end
            end
        end

        assign valid_w[k] = ctrl_q.valid;
        assign carry_w[k] = ctrl_q.carry;
        assign sum_w[k]   = sum_q;
        assign opa_w[k]   = opa_q;
        assign opb_w[k]   = opb_q;
    end

    assign in_ready  = stage_ready[0];
    assign out_valid = valid_w[STAGES-1];
    assign sum       = sum_w[STAGES-1];
    assign co        = carry_w[STAGES-1];

endmodule

// File: tb/tb_pipe_adder.sv
// tb/tb_pipe_adder.sv - self-checking bench for pipe_adder (32/4 and 8/2 builds)

module tb_pipe_adder;

    logic clk;
    int   tests = 0;
    int   fails = 0;

    // DUT 0: default WIDTH=32, STAGES=4
    logic        rst0, iv0, ir0, ci0, ov0, or0, co0;
    logic [31:0] a0, b0, sum0;

    // DUT 1: WIDTH=8, STAGES=2
    logic        rst1, iv1, ir1, ci1, ov1, or1, co1;
    logic [7:0]  a1, b1, sum1;
`ifdef PIPE_ADDER_SUB_EN
    logic        sub1;
`endif

    pipe_adder u_dut0 (
        .clk(clk), .rst(rst0), .in_valid(iv0), .in_ready(ir0),
        .a(a0), .b(b0), .ci(ci0),
`ifdef PIPE_ADDER_SUB_EN
        .sub(1'b0),
`endif
        .out_valid(ov0), .out_ready(or0), .sum(sum0), .co(co0)
    );

    pipe_adder #(.WIDTH(8), .STAGES(2)) u_dut1 (
        .clk(clk), .rst(rst1), .in_valid(iv1), .in_ready(ir1),
        .a(a1), .b(b1), .ci(ci1),
`ifdef PIPE_ADDER_SUB_EN
        .sub(sub1),
`endif
        .out_valid(ov1), .out_ready(or1), .sum(sum1), .co(co1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: every accepted input produces exactly one result,
    // in order, equal to the plain arithmetic sum.
    logic [32:0] q0[$];
    logic [8:0]  q1[$];

    always @(posedge clk) begin
        if (rst0) begin
            q0.delete();
        end else begin
            if (ov0 && or0 && q0.size() > 0) void'(q0.pop_front());
            if (iv0 && ir0) q0.push_back({1'b0, a0} + {1'b0, b0} + {32'd0, ci0});
        end
        if (rst1) begin
            q1.delete();
        end else begin
            if (ov1 && or1 && q1.size() > 0) void'(q1.pop_front());
            if (iv1 && ir1) begin
`ifdef PIPE_ADDER_SUB_EN
                if (sub1) q1.push_back({1'b0, a1} + {1'b0, ~b1} + 9'd1);
                else
`endif
                q1.push_back({1'b0, a1} + {1'b0, b1} + {8'd0, ci1});
            end
        end
    end

    always @(negedge clk) begin
        if (ov0) begin
            if (q0.size() == 0) begin
                tests++; fails++;
                $display("FAIL sb0_unexpected actual=%0h required=no output", sum0);
            end else begin
                check("sb0_result", {31'd0, co0, sum0}, {31'd0, q0[0]});
            end
        end
        if (ov1) begin
            if (q1.size() == 0) begin
                tests++; fails++;
                $display("FAIL sb1_unexpected actual=%0h required=no output", sum1);
            end else begin
                check("sb1_result", {55'd0, co1, sum1}, {55'd0, q1[0]});
            end
        end
    end

    logic [31:0] ta[4] = '{32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h1234_5678};
    logic [31:0] tb[4] = '{32'h2, 32'hFFFF_FFFF, 32'h8000_0000, 32'h1111_1111};
    logic        tc[4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        rst0 = 1; iv0 = 0; a0 = 0; b0 = 0; ci0 = 0; or0 = 1;
        rst1 = 1; iv1 = 0; a1 = 0; b1 = 0; ci1 = 0; or1 = 1;
`ifdef PIPE_ADDER_SUB_EN
        sub1 = 0;
`endif
        repeat (2) @(negedge clk);
        rst0 = 0; rst1 = 0;
        #1;
        check("reset_out_valid", ov0, 0);
        check("reset_sum", sum0, 0);
        check("reset_co", co0, 0);
        check("reset_in_ready", ir0, 1);
        check("reset_out_valid_w8", ov1, 0);
        @(negedge clk);

        // Carry ripples through every slice.
        a0 = 32'hFFFF_FFFF; b0 = 32'd1; ci0 = 0; iv0 = 1;
        @(negedge clk);
        iv0 = 0;
        for (int i = 1; i <= 4; i++) begin
            if (i < 4) begin
                check("t1_latency_out_valid", ov0, 0);
                @(negedge clk);
            end else begin
                check("t1_out_valid", ov0, 1);
                check("t1_sum", sum0, 32'h0);
                check("t1_co", co0, 1);
            end
        end
        @(negedge clk);

        // Fill the pipe under backpressure.
        or0 = 0; #1;
        for (int i = 0; i < 4; i++) begin
            check("t3_fill_in_ready", ir0, 1);
            a0 = ta[i]; b0 = tb[i]; ci0 = tc[i]; iv0 = 1;
            @(negedge clk);
        end
        a0 = 32'd0; b0 = 32'd0; ci0 = 1;
        check("t3_full_in_ready", ir0, 0);
        for (int s = 0; s < 6; s++) begin
            check("t3_stall_out_valid", ov0, 1);
            check("t3_stall_sum", sum0, 32'h3);
            check("t3_stall_co", co0, 0);
            check("t3_stall_in_ready", ir0, 0);
            @(negedge clk);
        end
        // Full pipe with downstream ready: push and pop together.
        or0 = 1; #1;
        check("t4_pop_push_in_ready", ir0, 1);
        @(negedge clk);
        iv0 = 0; or0 = 0; #1;
        check("t4_still_full", ir0, 0);
        check("t4_next_sum", sum0, 32'hFFFF_FFFF);
        check("t4_next_co", co0, 1);
        or0 = 1;
        repeat (8) @(negedge clk);
        check("t3_drained_out_valid", ov0, 0);
        check("t3_drained_outstanding", q0.size(), 0);

        // Reset with two ops in flight.
        a0 = 32'd5; b0 = 32'd6; ci0 = 0; iv0 = 1;
        @(negedge clk);
        a0 = 32'd7; b0 = 32'd8;
        @(negedge clk);
        iv0 = 0; rst0 = 1;
        @(negedge clk);
        rst0 = 0;
        check("t5_reset_out_valid", ov0, 0);
        check("t5_reset_sum", sum0, 0);
        a0 = 32'd10; b0 = 32'd20; ci0 = 1; iv0 = 1;
        @(negedge clk);
        iv0 = 0;
        for (int i = 1; i <= 4; i++) begin
            if (i < 4) begin
                check("t5_no_stale_out_valid", ov0, 0);
                @(negedge clk);
            end else begin
                check("t5_out_valid", ov0, 1);
                check("t5_sum", sum0, 32'd31);
                check("t5_co", co0, 0);
            end
        end
        @(negedge clk);

        // WIDTH=8, STAGES=2 back-to-back stream.
        a1 = 8'd3; b1 = 8'd4; ci1 = 0; iv1 = 1;
        @(negedge clk);
        check("t2_cycle1_out_valid", ov1, 0);
        a1 = 8'd200; b1 = 8'd100; ci1 = 1;
        @(negedge clk);
        check("t2_out0_valid", ov1, 1);
        check("t2_out0", {co1, sum1}, {1'b0, 8'd7});
        a1 = 8'd255; b1 = 8'd255; ci1 = 1;
        @(negedge clk);
        iv1 = 0;
        check("t2_out1", {ov1, co1, sum1}, {1'b1, 1'b1, 8'd45});
        @(negedge clk);
        check("t2_out2", {ov1, co1, sum1}, {1'b1, 1'b1, 8'd255});
        @(negedge clk);
        check("t2_idle_out_valid", ov1, 0);

`ifdef PIPE_ADDER_SUB_EN
        sub1 = 1; a1 = 8'd5; b1 = 8'd7; ci1 = 1; iv1 = 1;
        @(negedge clk);
        a1 = 8'd7; b1 = 8'd5; ci1 = 0;
        @(negedge clk);
        iv1 = 0;
        check("t6_sub_borrow", {ov1, co1, sum1}, {1'b1, 1'b0, 8'hFE});
        @(negedge clk);
        check("t6_sub_noborrow", {ov1, co1, sum1}, {1'b1, 1'b1, 8'h02});
        sub1 = 0;
        @(negedge clk);
`endif

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
